// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage of the 16-bit pipelined CPU:
// widths, FSM state encoding and MEM/WB bubble values.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMTOREG = 1'b0;
  localparam logic BUBBLE_ERR      = 1'b0;

  function automatic logic is_memop(input logic mem_write, input logic mem_to_reg);
    return mem_write | mem_to_reg;
  endfunction

endpackage

// File: rtl/memwb_register.sv
// MEM/WB pipeline register: loads the finished instruction on i_load,
// inserts a bubble (no register write, zeroed data) on i_bubble.
module memwb_register import cpu_pkg::*; #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic              i_err,
  input  logic              i_regwrite,
  input  logic              i_memtoreg,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic [REG_AW-1:0] i_write_reg,
  output logic              o_regwrite,
  output logic              o_memtoreg,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_read_data,
  output logic [REG_AW-1:0] o_write_reg,
  output logic              o_err
);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_regwrite   <= 1'b0;
      o_memtoreg   <= 1'b0;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_write_reg  <= '0;
      o_err        <= 1'b0;
    end else if (i_bubble) begin
      o_regwrite   <= BUBBLE_REGWRITE;
      o_memtoreg   <= BUBBLE_MEMTOREG;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_write_reg  <= '0;
      o_err        <= i_err;
    end else if (i_load) begin
      o_regwrite   <= i_regwrite;
      o_memtoreg   <= i_memtoreg;
      o_alu_result <= i_alu_result;
      o_read_data  <= i_read_data;
      o_write_reg  <= i_write_reg;
      o_err        <= BUBBLE_ERR;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: runs loads/stores over a req/ack handshake, stalls upstream
// while outstanding, and feeds MEM/WB. Define MEM_ACCESS_TIMEOUT_EN to abort
// accesses that see no ack within TIMEOUT cycles.
module memory_access_stage import cpu_pkg::*; #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int REG_AW  = cpu_pkg::REG_AW,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic              MemToRegM,
  input  logic              RegWriteM,
  input  logic [DATA_W-1:0] alu_resultM,
  input  logic [DATA_W-1:0] write_dataM,
  input  logic [REG_AW-1:0] write_regM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stallM,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [DATA_W-1:0] alu_resultW,
  output logic [DATA_W-1:0] read_dataW,
  output logic [REG_AW-1:0] write_regW,
  output logic              mem_errW
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("memory_access_stage: TIMEOUT must be at least 1");
  end

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_memop;
  logic              w_stall;
  logic              w_start;
  logic              w_done;
  logic              w_abort;
  logic              w_wb_load;
  logic              w_wb_bubble;
  logic              w_timeout_hit;
  logic              w_regwrite;
  logic              w_memtoreg;
  logic [DATA_W-1:0] w_read_data;

  assign w_memop    = is_memop(MemWriteM, MemToRegM);
  // A store with MemToRegM also set is still a store: nothing is written back.
  assign w_regwrite = RegWriteM & ~MemWriteM;
  assign w_memtoreg = MemToRegM & ~MemWriteM;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts completed ack-free ACCESS cycles; the TIMEOUT-th one aborts.
  assign w_timeout_hit = (r_state == ACCESS) && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_wb_load    = 1'b0;
    w_wb_bubble  = 1'b0;
    w_read_data  = '0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_stall      = 1'b1;
          w_start      = 1'b1;
          w_wb_bubble  = 1'b1;
          w_next_state = ACCESS;
        end else begin
          w_wb_load    = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          w_done       = 1'b1;
          w_wb_load    = 1'b1;
          w_read_data  = r_we ? '0 : mem_rdata;
          w_next_state = IDLE;
        end else if (w_timeout_hit) begin
          w_abort      = 1'b1;
          w_wb_bubble  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_stall      = 1'b1;
          w_wb_bubble  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request side is fully registered and held stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= MemWriteM;
      r_addr  <= alu_resultM;
      r_wdata <= write_dataM;
    end else if (w_done || w_abort) begin
      r_req   <= 1'b0;
    end
  end

  memwb_register #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_memwb (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_wb_load),
    .i_bubble    (w_wb_bubble),
    .i_err       (w_abort),
    .i_regwrite  (w_regwrite),
    .i_memtoreg  (w_memtoreg),
    .i_alu_result(alu_resultM),
    .i_read_data (w_read_data),
    .i_write_reg (write_regM),
    .o_regwrite  (RegWriteW),
    .o_memtoreg  (MemToRegW),
    .o_alu_result(alu_resultW),
    .o_read_data (read_dataW),
    .o_write_reg (write_regW),
    .o_err       (mem_errW)
  );

  assign stallM    = w_stall;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed vector table, reset and
// timeout sequences, then randomized instructions against a transaction model.
module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic        MemWriteM, MemToRegM, RegWriteM;
  logic [15:0] alu_resultM, write_dataM;
  logic [2:0]  write_regM;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stallM;
  logic        RegWriteW, MemToRegW;
  logic [15:0] alu_resultW, read_dataW;
  logic [2:0]  write_regW;
  logic        mem_errW;

  int checks   = 0;
  int failures = 0;

  memory_access_stage #(.DATA_W(16), .REG_AW(3), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
    .alu_resultM(alu_resultM), .write_dataM(write_dataM), .write_regM(write_regM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stallM(stallM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .alu_resultW(alu_resultW),
    .read_dataW(read_dataW), .write_regW(write_regW), .mem_errW(mem_errW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mw, mr, rw;
    logic [15:0] alu, wdata;
    logic [2:0]  wreg;
    int          lat;
    logic [15:0] rdata;
    logic        exp_rw, exp_mtr;
    logic [15:0] exp_alu, exp_rd;
    logic [2:0]  exp_wreg;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] w_vec();
    return {26'd0, RegWriteW, MemToRegW, alu_resultW, read_dataW, write_regW, mem_errW};
  endfunction

  // Writeback outcome of one instruction: stores write nothing back and carry no
  // read data; loads return the memory word; ALU ops pass straight through.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r          = v;
    r.exp_rw   = v.mw ? 1'b0 : v.rw;
    r.exp_mtr  = v.mr & ~v.mw;
    r.exp_alu  = v.alu;
    r.exp_rd   = (v.mr & ~v.mw) ? v.rdata : 16'h0000;
    r.exp_wreg = v.wreg;
    return r;
  endfunction

  task automatic drive_m(input logic mw, input logic mr, input logic rw,
                         input logic [15:0] alu, input logic [15:0] wdata, input logic [2:0] wreg);
    MemWriteM   = mw;
    MemToRegM   = mr;
    RegWriteM   = rw;
    alu_resultM = alu;
    write_dataM = wdata;
    write_regM  = wreg;
  endtask

  // Entered and left at posedge+1. The M inputs stay frozen while stallM is high.
  task automatic run_instr(input vec_t v, input string tag);
    logic [63:0] exp_w;
    logic        memop;
    exp_w = {26'd0, v.exp_rw, v.exp_mtr, v.exp_alu, v.exp_rd, v.exp_wreg, 1'b0};
    memop = v.mw | v.mr;
    drive_m(v.mw, v.mr, v.rw, v.alu, v.wdata, v.wreg);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    check({tag, "_stall_first"}, 64'(stallM), 64'(memop));
    if (memop) begin
      @(posedge clk); #1;
      check({tag, "_req"}, 64'({mem_req, mem_we, mem_addr, mem_wdata}),
            64'({1'b1, v.mw, v.alu, v.wdata}));
      check({tag, "_bubble"}, w_vec(), 64'd0);
      for (int k = 0; k < v.lat; k++) begin
        #1;
        check({tag, "_stall_wait"}, 64'(stallM), 64'd1);
        @(posedge clk); #1;
        check({tag, "_req_hold"}, 64'({mem_req, mem_we, mem_addr, mem_wdata}),
              64'({1'b1, v.mw, v.alu, v.wdata}));
        check({tag, "_bubble_wait"}, w_vec(), 64'd0);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      #1;
      check({tag, "_stall_ack"}, 64'(stallM), 64'd0);
    end
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    check({tag, "_req_low"}, 64'(mem_req), 64'd0);
    check({tag, "_wb"}, w_vec(), exp_w);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    //        mw    mr    rw    alu       wdata     wreg  lat rdata     erw   emtr  ealu      erd       ewreg
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 3'd3, 0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000, 3'd3};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd5, 0, 16'hBEEF, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 3'd5};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 3'd0, 3, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 3'd1, 0, 16'h1111, 1'b1, 1'b1, 16'h0002, 16'h1111, 3'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000, 3'd2, 1, 16'h2222, 1'b1, 1'b1, 16'h0004, 16'h2222, 3'd2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0100, 16'h5A5A, 3'd7, 2, 16'hDEAD, 1'b0, 1'b0, 16'h0100, 16'h0000, 3'd7};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 3'd6, 0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 3'd6};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'hFFFE, 16'hFFFF, 3'd4, 0, 16'hCAFE, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 3'd4};

    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    drive_m(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
    check("reset_w", w_vec(), 64'd0);
    reset = 1'b0;
    #1;
    check("reset_stall", 64'(stallM), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the second ACCESS cycle kills the access; a late ack is ignored.
    drive_m(1'b0, 1'b1, 1'b1, 16'h0022, 16'h0000, 3'd4);
    @(posedge clk); #1;
    check("rst_mid_req", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
    check("rst_mid_w", w_vec(), 64'd0);
    reset = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    #1;
    check("late_ack_stall", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    check("late_ack_req", 64'(mem_req), 64'd0);
    check("late_ack_w", w_vec(), 64'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack ever: four ACCESS cycles, then the access is dropped with an error bubble.
    drive_m(1'b0, 1'b1, 1'b1, 16'h0080, 16'h0000, 3'd2);
    #1;
    check("to_stall_idle", 64'(stallM), 64'd1);
    @(posedge clk); #1;
    check("to_req", 64'(mem_req), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("to_stall_c%0d", k), 64'(stallM), 64'(k < 4));
      @(posedge clk); #1;
      check($sformatf("to_req_c%0d", k), 64'(mem_req), 64'(k < 4));
      check($sformatf("to_err_c%0d", k), 64'({RegWriteW, mem_errW}), 64'({1'b0, k == 4}));
    end
    drive_m(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    #1;
    check("to_after_stall", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    check("to_err_clear", 64'(mem_errW), 64'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind     = int'($urandom_range(0, 3));
      rv.mw    = (kind == 2) || (kind == 3);
      rv.mr    = (kind == 1) || (kind == 3);
      rv.rw    = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rv.alu   = 16'($urandom);
      rv.wdata = 16'($urandom);
      rv.wreg  = 3'($urandom);
      rv.lat   = int'($urandom_range(0, 3));
      rv.rdata = 16'($urandom);
      rv.exp_rw = 1'b0; rv.exp_mtr = 1'b0; rv.exp_alu = 16'h0; rv.exp_rd = 16'h0; rv.exp_wreg = 3'd0;
      run_instr(model(rv), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
